// File: rtl/frame_buffer_scheduler.sv
// Tear-free 2..4 frame buffer scheduler between camera write and VGA read paths.
// Optional `FBS_FREEZE_EN adds i_freeze to hold the displayed buffer.
module frame_buffer_scheduler #(
  parameter int              NUM_BUF     = 3,
  parameter int              ADDR_W      = 23,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0] BUF_STRIDE = 23'h080000,
  parameter int              FRAME_WORDS = 153600
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
`ifdef FBS_FREEZE_EN
  input  logic              i_freeze,
`endif
  input  logic              i_wr_frame_start,
  input  logic              i_wr_frame_end,
  input  logic              i_rd_frame_start,
  output logic [ADDR_W-1:0] o_wr_base,
  output logic [ADDR_W-1:0] o_wr_max,
  output logic              o_wr_load,
  output logic [ADDR_W-1:0] o_rd_base,
  output logic [ADDR_W-1:0] o_rd_max,
  output logic              o_rd_load,
  output logic [1:0]        o_wr_idx,
  output logic [1:0]        o_rd_idx,
  output logic              o_wr_drop,
  output logic [15:0]       o_frame_cnt
);

  localparam logic [0:0] W_IDLE   = 1'b0;
  localparam logic [0:0] W_ACTIVE = 1'b1;

  logic [0:0]  state, state_n;
  logic [1:0]  rd_idx, rd_n;
  logic [1:0]  wr_idx, wr_n;
  logic [1:0]  ready_idx, ready_idx_n;
  logic        ready_valid, ready_valid_n;
  logic [15:0] cnt_n;
  logic        drop_n;
  logic        wr_load_n;
  logic        rd_load_n;
  logic        found;
  logic [1:0]  pick;
  logic        freeze;

`ifdef FBS_FREEZE_EN
  assign freeze = i_freeze;
`else
  assign freeze = 1'b0;
`endif

  function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] idx);
    return BASE_ADDR + ADDR_W'(idx) * BUF_STRIDE;
  endfunction

  function automatic logic [ADDR_W-1:0] max_of(input logic [1:0] idx);
    return base_of(idx) + ADDR_W'(FRAME_WORDS);
  endfunction

  // Commit, then read switch, then writer selection on the updated state.
  always_comb begin
    state_n       = state;
    rd_n          = rd_idx;
    wr_n          = wr_idx;
    ready_idx_n   = ready_idx;
    ready_valid_n = ready_valid;
    cnt_n         = o_frame_cnt;
    drop_n        = 1'b0;
    wr_load_n     = 1'b0;
    rd_load_n     = 1'b0;
    found         = 1'b0;
    pick          = 2'd0;

    if (state == W_ACTIVE && i_wr_frame_end) begin
      drop_n        = ready_valid;
      ready_idx_n   = wr_idx;
      ready_valid_n = 1'b1;
      cnt_n         = o_frame_cnt + 16'd1;
      state_n       = W_IDLE;
    end

    if (i_rd_frame_start) begin
      rd_load_n = 1'b1;
      if (ready_valid_n && !freeze) begin
        rd_n          = ready_idx_n;
        ready_valid_n = 1'b0;
      end
    end

    if (i_wr_frame_start && (state_n == W_ACTIVE || i_enable)) begin
      if (state_n == W_ACTIVE) drop_n = 1'b1;
      for (int i = NUM_BUF - 1; i >= 0; i--) begin
        if (2'(i) != rd_n &&
            !(ready_valid_n && 2'(i) == ready_idx_n)) begin
          found = 1'b1;
          pick  = 2'(i);
        end
      end
      if (found) begin
        wr_n = pick;
      end else begin
        // Only reachable with two buffers: steal the pending ready frame.
        wr_n          = ready_idx_n;
        ready_valid_n = 1'b0;
        drop_n        = 1'b1;
      end
      state_n   = W_ACTIVE;
      wr_load_n = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= W_IDLE;
      rd_idx      <= 2'd0;
      wr_idx      <= 2'd1;
      ready_idx   <= 2'd0;
      ready_valid <= 1'b0;
      o_frame_cnt <= 16'd0;
      o_wr_drop   <= 1'b0;
      o_wr_load   <= 1'b0;
      o_rd_load   <= 1'b0;
      o_rd_base   <= base_of(2'd0);
      o_rd_max    <= max_of(2'd0);
      o_wr_base   <= base_of(2'd1);
      o_wr_max    <= max_of(2'd1);
    end else begin
      state       <= state_n;
      rd_idx      <= rd_n;
      wr_idx      <= wr_n;
      ready_idx   <= ready_idx_n;
      ready_valid <= ready_valid_n;
      o_frame_cnt <= cnt_n;
      o_wr_drop   <= drop_n;
      o_wr_load   <= wr_load_n;
      o_rd_load   <= rd_load_n;
      if (wr_load_n) begin
        o_wr_base <= base_of(wr_n);
        o_wr_max  <= max_of(wr_n);
      end
      if (rd_load_n) begin
        o_rd_base <= base_of(rd_n);
        o_rd_max  <= max_of(rd_n);
      end
    end
  end

  assign o_wr_idx = wr_idx;
  assign o_rd_idx = rd_idx;

endmodule
